// File: rtl/tlp_vc_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tlp_vc_dispatch_pkg
// Brief    : Shared constants and state encoding for the VC dispatch sequencer.
// Revision : 1.0
// ============================================================================
package tlp_vc_dispatch_pkg;

    localparam int c_num_vc     = 4;
    localparam int c_id_w       = 2;
    localparam int c_default_dw = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tlp_vc_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module   : tlp_vc_dispatch_if
// Brief    : Grant, source-FIFO and destination-FIFO signal bundle.
//            Statistics signals present when TLP_VC_DISPATCH_STATS_EN is defined.
// Revision : 1.0
// ============================================================================
interface tlp_vc_dispatch_if #(
    parameter int DW = tlp_vc_dispatch_pkg::c_default_dw
);
    import tlp_vc_dispatch_pkg::*;

    logic              arb_valid;
    logic [c_id_w-1:0] arb_id;
    logic              empty0, empty1, empty2, empty3;
    logic [DW-1:0]     data_in0, data_in1, data_in2, data_in3;
    logic              dest_almost_full;
    logic              pop0, pop1, pop2, pop3;
    logic              push;
    logic [DW-1:0]     data_out;
    logic [c_id_w-1:0] active_id;
    logic              busy;
    logic              burst_done;
`ifdef TLP_VC_DISPATCH_STATS_EN
    logic [15:0]       words_sent;
    logic [7:0]        short_bursts;

    modport master (
        output arb_valid, arb_id, empty0, empty1, empty2, empty3,
               data_in0, data_in1, data_in2, data_in3, dest_almost_full,
        input  pop0, pop1, pop2, pop3, push, data_out, active_id, busy,
               burst_done, words_sent, short_bursts
    );
    modport slave (
        input  arb_valid, arb_id, empty0, empty1, empty2, empty3,
               data_in0, data_in1, data_in2, data_in3, dest_almost_full,
        output pop0, pop1, pop2, pop3, push, data_out, active_id, busy,
               burst_done, words_sent, short_bursts
    );
`else
    modport master (
        output arb_valid, arb_id, empty0, empty1, empty2, empty3,
               data_in0, data_in1, data_in2, data_in3, dest_almost_full,
        input  pop0, pop1, pop2, pop3, push, data_out, active_id, busy,
               burst_done
    );
    modport slave (
        input  arb_valid, arb_id, empty0, empty1, empty2, empty3,
               data_in0, data_in1, data_in2, data_in3, dest_almost_full,
        output pop0, pop1, pop2, pop3, push, data_out, active_id, busy,
               burst_done
    );
`endif

endinterface
`default_nettype wire

// File: rtl/tlp_vc_mux4.sv
`default_nettype none
// ============================================================================
// Module   : tlp_vc_mux4
// Brief    : Selects head data / empty flag of one VC and decodes its pop strobe.
// Revision : 1.0
// ============================================================================
module tlp_vc_mux4 import tlp_vc_dispatch_pkg::*; #(
    parameter int DW = c_default_dw
) (
    input  wire logic [c_id_w-1:0]   i_sel,
    input  wire logic                i_pop_en,
    input  wire logic [c_num_vc-1:0] i_empty,
    input  wire logic [DW-1:0]       i_data0,
    input  wire logic [DW-1:0]       i_data1,
    input  wire logic [DW-1:0]       i_data2,
    input  wire logic [DW-1:0]       i_data3,
    output logic      [DW-1:0]       o_data,
    output logic                     o_empty,
    output logic      [c_num_vc-1:0] o_pop
);

    logic [DW-1:0] w_data [c_num_vc];
    logic          w_fire;

    assign w_data[0] = i_data0;
    assign w_data[1] = i_data1;
    assign w_data[2] = i_data2;
    assign w_data[3] = i_data3;

    assign o_data  = w_data[i_sel];
    assign o_empty = i_empty[i_sel];
    assign w_fire  = i_pop_en & ~o_empty;

    // Only the selected VC can ever see a strobe, so the vector is one-hot or zero.
    for (genvar k = 0; k < c_num_vc; k++) begin : g_pop
        assign o_pop[k] = w_fire & (i_sel == c_id_w'(k));
    end

endmodule
`default_nettype wire

// File: rtl/tlp_vc_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tlp_vc_dispatch
// Brief    : Per-grant burst sequencer draining one FWFT source VC into the
//            shared destination FIFO. Optional stats: TLP_VC_DISPATCH_STATS_EN.
// Revision : 1.0
// ============================================================================
module tlp_vc_dispatch import tlp_vc_dispatch_pkg::*; #(
    parameter int DW    = c_default_dw,
    parameter int BURST = 4,
    parameter int CW    = 4
) (
    input wire logic      clk,
    input wire logic      reset,
    tlp_vc_dispatch_if.slave bus
);

    state_t              r_state;
    logic [c_id_w-1:0]   r_id;
    logic [CW-1:0]       r_cnt;
    logic                r_push;
    logic [DW-1:0]       r_data;
    logic                r_busy;
    logic                r_burst_done;

    logic [c_id_w-1:0]   w_sel;
    logic                w_pop_en;
    logic [DW-1:0]       w_data;
    logic                w_empty;
    logic [c_num_vc-1:0] w_pop;
    logic                w_pop_any;
    logic [CW-1:0]       w_cnt_inc;

    // In IDLE the mux looks at the offered grant so the empty check uses its VC.
    assign w_sel     = (r_state == ST_IDLE) ? bus.arb_id : r_id;
    assign w_pop_en  = (r_state == ST_XFER) & ~bus.dest_almost_full;
    assign w_pop_any = |w_pop;
    assign w_cnt_inc = r_cnt + 1'b1;

    tlp_vc_mux4 #(.DW(DW)) u_mux (
        .i_sel    (w_sel),
        .i_pop_en (w_pop_en),
        .i_empty  ({bus.empty3, bus.empty2, bus.empty1, bus.empty0}),
        .i_data0  (bus.data_in0),
        .i_data1  (bus.data_in1),
        .i_data2  (bus.data_in2),
        .i_data3  (bus.data_in3),
        .o_data   (w_data),
        .o_empty  (w_empty),
        .o_pop    (w_pop)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_id         <= '0;
            r_cnt        <= '0;
            r_push       <= 1'b0;
            r_data       <= '0;
            r_busy       <= 1'b0;
            r_burst_done <= 1'b0;
        end else begin
            r_push       <= w_pop_any;
            r_burst_done <= 1'b0;
            if (w_pop_any) begin
                r_data <= w_data;
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.arb_valid && !w_empty) begin
                        r_id    <= bus.arb_id;
                        r_cnt   <= '0;
                        r_state <= ST_XFER;
                        r_busy  <= 1'b1;
                    end
                end
                ST_XFER: begin
                    if (w_pop_any) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == CW'(BURST)) begin
                            r_state      <= ST_DONE;
                            r_burst_done <= 1'b1;
                        end
                    end else if (w_empty) begin
                        // Source ran dry (possibly zero-length): nothing left to move.
                        r_state      <= ST_DONE;
                        r_burst_done <= 1'b1;
                    end else begin
                        r_state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (w_empty) begin
                        r_state      <= ST_DONE;
                        r_burst_done <= 1'b1;
                    end else if (!bus.dest_almost_full) begin
                        r_state <= ST_XFER;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pop0       = w_pop[0];
    assign bus.pop1       = w_pop[1];
    assign bus.pop2       = w_pop[2];
    assign bus.pop3       = w_pop[3];
    assign bus.push       = r_push;
    assign bus.data_out   = r_data;
    assign bus.active_id  = r_id;
    assign bus.busy       = r_busy;
    assign bus.burst_done = r_burst_done;

`ifdef TLP_VC_DISPATCH_STATS_EN
    logic [15:0] r_words_sent;
    logic [7:0]  r_short_bursts;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_words_sent   <= '0;
            r_short_bursts <= '0;
        end else begin
            if (r_push && (r_words_sent != 16'hFFFF)) begin
                r_words_sent <= r_words_sent + 16'd1;
            end
            if ((r_state == ST_DONE) && (r_cnt < CW'(BURST)) && (r_short_bursts != 8'hFF)) begin
                r_short_bursts <= r_short_bursts + 8'd1;
            end
        end
    end

    assign bus.words_sent   = r_words_sent;
    assign bus.short_bursts = r_short_bursts;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tlp_vc_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_tlp_vc_dispatch
// Brief    : Self-checking bench with FWFT source-FIFO model and burst scoreboard.
// Revision : 1.0
// ============================================================================
module tb_tlp_vc_dispatch;

    localparam int DW    = 6;
    localparam int BURST = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tlp_vc_dispatch_if #(.DW(DW)) bus ();

    tlp_vc_dispatch #(.DW(DW), .BURST(BURST), .CW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int exp_words = 0;
    int exp_short = 0;

    // Source FIFO model: circular memories, read pointers advance on pop strobes.
    logic [DW-1:0] src_mem [4][256];
    logic [7:0]    rd_ptr  [4] = '{default: 8'd0};
    logic [7:0]    wr_ptr  [4] = '{default: 8'd0};
    logic [3:0]    pops;

    assign pops = {bus.pop3, bus.pop2, bus.pop1, bus.pop0};

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (pops[k] === 1'b1) rd_ptr[k] <= rd_ptr[k] + 8'd1;
        end
    end

    assign bus.empty0   = (rd_ptr[0] == wr_ptr[0]);
    assign bus.empty1   = (rd_ptr[1] == wr_ptr[1]);
    assign bus.empty2   = (rd_ptr[2] == wr_ptr[2]);
    assign bus.empty3   = (rd_ptr[3] == wr_ptr[3]);
    assign bus.data_in0 = src_mem[0][rd_ptr[0]];
    assign bus.data_in1 = src_mem[1][rd_ptr[1]];
    assign bus.data_in2 = src_mem[2][rd_ptr[2]];
    assign bus.data_in3 = src_mem[3][rd_ptr[3]];

    task automatic load(input int id, input int n, input int base);
        for (int i = 0; i < n; i++) begin
            src_mem[id][wr_ptr[id]] = (base < 0) ? DW'($urandom) : DW'(base + i);
            wr_ptr[id] = wr_ptr[id] + 8'd1;
        end
    endtask

    // Grant one burst and score it cycle by cycle until busy drops.
    task automatic run_burst(input int id, input int af_mode, input bit toggle,
                             output int done_cyc, output logic [31:0] pop_mask);
        logic [DW-1:0] exp_q [$];
        logic [DW-1:0] ex;
        logic [3:0]    onehot;
        int avail, exp_n, pushes, bd, remaining;
        bit fin, done_seen, prev_pop;
        avail     = int'(8'(wr_ptr[id] - rd_ptr[id]));
        exp_n     = (avail < BURST) ? avail : BURST;
        for (int i = 0; i < exp_n; i++) exp_q.push_back(src_mem[id][8'(rd_ptr[id] + 8'(i))]);
        onehot    = 4'b0001 << id;
        done_cyc  = -1;
        pop_mask  = '0;
        pushes    = 0;
        bd        = 0;
        fin       = 0;
        done_seen = 0;
        prev_pop  = 0;
        @(negedge clk);
        bus.arb_valid = 1'b1;
        bus.arb_id    = 2'(id);
        bus.dest_almost_full = 1'b0;
        for (int c = 0; c < 100 && !fin; c++) begin
            @(negedge clk);
            if (!done_seen) begin
                if (toggle) begin
                    bus.arb_valid = 1'b1;
                    bus.arb_id    = (c % 2 == 0) ? 2'd2 : 2'd1;
                end else begin
                    bus.arb_valid = 1'b0;
                end
                case (af_mode)
                    1:       bus.dest_almost_full = ($urandom_range(0, 2) == 0);
                    2:       bus.dest_almost_full = (c >= 1 && c <= 3);
                    default: bus.dest_almost_full = 1'b0;
                endcase
            end else begin
                bus.arb_valid = 1'b0;
                bus.dest_almost_full = 1'b0;
            end
            #1;
            n_vec++;
            if (pops != 4'b0 && pops != onehot) begin
                n_err++; $display("FAIL pop_select: pops=%b allowed=%b", pops, onehot);
            end
            n_vec++;
            if (pops != 4'b0 && bus.dest_almost_full) begin
                n_err++; $display("FAIL pop_while_af: pops=%b required 0000", pops);
            end
            n_vec++;
            if (bus.push !== prev_pop) begin
                n_err++; $display("FAIL push_latency: push=%b required %b", bus.push, prev_pop);
            end
            if (bus.push === 1'b1) begin
                pushes++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL extra_push: data=%h required no push", bus.data_out);
                end else begin
                    ex = exp_q.pop_front();
                    if (bus.data_out !== ex) begin
                        n_err++; $display("FAIL push_data: data=%h required %h", bus.data_out, ex);
                    end
                end
            end
            n_vec++;
            if (bus.active_id !== 2'(id)) begin
                n_err++; $display("FAIL active_id: got %0d required %0d", bus.active_id, id);
            end
            n_vec++;
            if (done_seen) begin
                fin = 1;
                if (bus.busy !== 1'b0) begin
                    n_err++; $display("FAIL busy_after_done: got %b required 0", bus.busy);
                end
            end else if (bus.busy !== 1'b1) begin
                n_err++; $display("FAIL busy_in_burst: got %b required 1", bus.busy);
            end
            if (bus.burst_done === 1'b1) begin
                bd++;
                if (!done_seen) done_cyc = c;
                done_seen = 1;
            end
            if (pops != 4'b0 && c < 32) pop_mask[c] = 1'b1;
            prev_pop = (pops != 4'b0);
        end
        remaining = int'(8'(wr_ptr[id] - rd_ptr[id]));
        n_vec++;
        if (!fin) begin n_err++; $display("FAIL burst_timeout: finished=0 required 1"); end
        n_vec++;
        if (pushes != exp_n) begin n_err++; $display("FAIL push_count: got %0d required %0d", pushes, exp_n); end
        n_vec++;
        if (bd != 1) begin n_err++; $display("FAIL burst_done_count: got %0d required 1", bd); end
        n_vec++;
        if (remaining != avail - exp_n) begin
            n_err++; $display("FAIL source_left: got %0d required %0d", remaining, avail - exp_n);
        end
        exp_words += exp_n;
        if (exp_n < BURST) exp_short++;
`ifdef TLP_VC_DISPATCH_STATS_EN
        n_vec++;
        if (bus.words_sent !== 16'(exp_words)) begin
            n_err++; $display("FAIL words_sent: got %0d required %0d", bus.words_sent, exp_words);
        end
        n_vec++;
        if (bus.short_bursts !== 8'(exp_short)) begin
            n_err++; $display("FAIL short_bursts: got %0d required %0d", bus.short_bursts, exp_short);
        end
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.arb_valid = 1'b1;
        bus.arb_id = 2'd1;
        bus.dest_almost_full = 1'b0;
        load(1, 1, 'h2A);
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (pops !== 4'b0 || bus.push !== 1'b0 || bus.data_out !== '0 || bus.active_id !== 2'd0 ||
            bus.busy !== 1'b0 || bus.burst_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: pops=%b push=%b data=%h id=%0d busy=%b done=%b required all 0",
                     pops, bus.push, bus.data_out, bus.active_id, bus.busy, bus.burst_done);
        end
`ifdef TLP_VC_DISPATCH_STATS_EN
        n_vec++;
        if (bus.words_sent !== 16'd0 || bus.short_bursts !== 8'd0) begin
            n_err++; $display("FAIL reset_stats: words=%0d short=%0d required 0 0", bus.words_sent, bus.short_bursts);
        end
`endif
        bus.arb_valid = 1'b0;
        reset = 1'b0;
        exp_words = 0;
        exp_short = 0;
    endtask

    task automatic test_full_burst();
        int dc; logic [31:0] pm;
        load(2, 6, 'h11);
        run_burst(2, 0, 0, dc, pm);
        n_vec++;
        if (pm !== 32'h0000_000F) begin n_err++; $display("FAIL full_pop_timing: mask=%h required 0000000f", pm); end
        n_vec++;
        if (dc != 4) begin n_err++; $display("FAIL full_done_cycle: got %0d required 4", dc); end
        n_vec++;
        if (src_mem[2][rd_ptr[2]] !== 6'h15) begin
            n_err++; $display("FAIL full_source_head: got %h required 15", src_mem[2][rd_ptr[2]]);
        end
    endtask

    task automatic test_short_burst();
        int dc; logic [31:0] pm;
        load(0, 2, -1);
        run_burst(0, 0, 0, dc, pm);
        n_vec++;
        if (pm !== 32'h0000_0003) begin n_err++; $display("FAIL short_pop_timing: mask=%h required 00000003", pm); end
        n_vec++;
        if (dc != 3) begin n_err++; $display("FAIL short_done_cycle: got %0d required 3", dc); end
    endtask

    task automatic test_hold();
        int dc; logic [31:0] pm;
        load(3, 4, -1);
        run_burst(3, 2, 0, dc, pm);
        n_vec++;
        if (pm !== 32'h0000_00E1) begin n_err++; $display("FAIL hold_pop_timing: mask=%h required 000000e1", pm); end
        n_vec++;
        if (dc != 8) begin n_err++; $display("FAIL hold_done_cycle: got %0d required 8", dc); end
    endtask

    task automatic test_grant_ignored_mid_burst();
        int dc; logic [31:0] pm;
        load(1, 4, -1);
        run_burst(1, 0, 1, dc, pm);
    endtask

    task automatic test_reset_mid_burst();
        int dc; logic [31:0] pm;
        load(3, 6, -1);
        @(negedge clk);
        bus.arb_valid = 1'b1;
        bus.arb_id = 2'd3;
        @(negedge clk);
        bus.arb_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        n_vec++;
        if (bus.push !== 1'b0 || bus.busy !== 1'b0 || bus.burst_done !== 1'b0 || pops !== 4'b0) begin
            n_err++;
            $display("FAIL midreset_outputs: push=%b busy=%b done=%b pops=%b required 0 0 0 0000",
                     bus.push, bus.busy, bus.burst_done, pops);
        end
        reset = 1'b0;
        exp_words = 0;
        exp_short = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (bus.burst_done !== 1'b0 || bus.busy !== 1'b0) begin
                n_err++; $display("FAIL midreset_quiet: done=%b busy=%b required 0 0", bus.burst_done, bus.busy);
            end
        end
        run_burst(3, 1, 0, dc, pm);
    endtask

    task automatic test_random_bursts();
        int dc; logic [31:0] pm; int id;
        for (int i = 0; i < 10; i++) begin
            id = $urandom_range(0, 3);
            load(id, $urandom_range(1, 7), -1);
            run_burst(id, 1, 0, dc, pm);
        end
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_short_burst();
        test_hold();
        test_grant_ignored_mid_burst();
        test_reset_mid_burst();
        test_random_bursts();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: sim time exceeded required finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
